toplevel_c5g_gpio: RTL and testbench
====================================

TOPLEVEL_C5G_GPIO -- requirements
Module: toplevel_c5g_gpio

Interface
REQ-001 SHALL have parameters: ADDR_W, default 4, RAM address width; DATA_W, default 8, RAM word width (DEPTH = 2**ADDR_W).
REQ-002 SHALL have one clock and a synchronous active-high reset.
REQ-003 CLOCK_50_B5B  in  1  sole clock, 50 MHz; all logic on its rising edge.
REQ-004 CPU_RESET  in  1  synchronous active-high reset.
REQ-005 CLOCK_125_p, CLOCK_50_B6A, CLOCK_50_B7A, CLOCK_50_B8A  in  1 each  unused, no logic attached.
REQ-006 KEY  in  4  push buttons, active-low (0 = pressed), asynchronous to clock.
REQ-007 SW  in  10  slide switches; SW[7:0] = write data, SW[9:8] unused.
REQ-008 LEDG  out  8  [3:0] current address, [7:4] = 0.
REQ-009 LEDR  out  10  [7:0] = SW[7:0] combinational echo, [8] = clear busy, [9] = 0.
REQ-010 HEX0  out  7  active-low seven-segment, read-data low nibble.
REQ-011 HEX1  out  7  active-low seven-segment, read-data high nibble.
REQ-012 GPIO  out  36  [7:0] read data, [11:8] address, [12] write strobe, [35:13] = 0; always driven.

Function
REQ-013 Each KEY bit SHALL pass a 2-flop synchronizer plus a previous-value flop; a press event SHALL be a one-cycle pulse when synchronized value goes 1->0.
REQ-014 Press event SHALL occur on the 3rd rising clock edge after KEY falls; no debounce.
REQ-015 KEY[0] press SHALL write SW[7:0] to mem[addr]; GPIO[12] high that same cycle only.
REQ-016 KEY[1] press SHALL increment addr modulo DEPTH (15->0).
REQ-017 KEY[2] press SHALL decrement addr modulo DEPTH (0->15).
REQ-018 KEY[3] press SHALL enter CLEAR state.
REQ-019 Simultaneous events: priority KEY[3] > KEY[0] > KEY[1] > KEY[2]; only the highest acts, others discarded.
REQ-020 FSM states IDLE and CLEAR; IDLE->CLEAR on KEY[3] event; CLEAR writes 0 to words 0..DEPTH-1, one per cycle, via internal counter; CLEAR->IDLE after word DEPTH-1 (DEPTH cycles total).
REQ-021 In CLEAR, LEDR[8] = 1, all key events discarded, addr unchanged; GPIO[12] stays 0.
REQ-022 RAM SHALL be synchronous, single-port, read-first: rd_data = mem[addr] registered, 1-cycle latency; during a write the old word is read, new word visible on the following cycle.
REQ-023 Address change SHALL reach LEDG same cycle as the addr register, rd_data one cycle later.
REQ-024 Segment map bit0=a..bit6=g, active-low; 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-025 HEX outputs SHALL be combinational decode of registered rd_data.

Reset
REQ-026 Reset SHALL set addr=0, rd_data=0, FSM=IDLE, clear counter=0, synchronizer and previous-value flops = 0.
REQ-027 Consequence: after reset HEX0=HEX1=0x40, LEDG=0x00, LEDR[8]=0, GPIO[12:0]=0; a key held through reset produces no event until released and pressed again.
REQ-028 RAM contents SHALL NOT be affected by reset; power-up content all zeros.
REQ-029 Reset mid-CLEAR SHALL abort to IDLE; words already cleared stay cleared.

Structure
REQ-030 Shared package SHALL hold ADDR_W/DATA_W defaults, FSM state enum {IDLE, CLEAR}, seven-segment decode function.
REQ-031 One sub-module spram: parameterized single-port synchronous RAM (we, addr, wdata, rdata); write mux (user vs clear) in the top.

Verification
REQ-032 Reset, KEY=0, SW=0 held 2000 cycles -> HEX0=HEX1=0x40, LEDG=0, GPIO=0, no writes.
REQ-033 SW=0xA5, KEY[0] pulse low -> one GPIO[12] pulse; next cycles HEX1=0x08 (A), HEX0=0x12 (5), GPIO[7:0]=0xA5.
REQ-034 Addr 0, KEY[2] press -> LEDG[3:0]=0xF; KEY[1] press -> 0x0.
REQ-035 Write 0x3C at addr 2 and 0x7E at addr 3, KEY[3] press -> LEDR[8] high exactly 16 cycles; afterwards both read 0x00.
REQ-036 KEY[0] and KEY[1] fall same cycle -> write occurs, addr unchanged.
REQ-037 Reset asserted at cycle 5 of CLEAR -> FSM IDLE, LEDR[8]=0, words 0..4 zero, words 5..15 retain data.

Source files
------------

// File: rtl/c5g_gpio_pkg.sv
// Shared types and helpers for the C5G GPIO RAM demo.
// Holds width defaults, FSM states and the seven-segment decoder.
package c5g_gpio_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Active-low segments, bit0 = a .. bit6 = g
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/toplevel_c5g_gpio_spram.sv
// Single-port synchronous read-first RAM.
// Read register resets; array contents do not.
module toplevel_c5g_gpio_spram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/toplevel_c5g_gpio.sv
// Key-driven RAM editor: browse, write and bulk-clear a small RAM,
// showing address on LEDG, data on HEX and a trace on GPIO.
module toplevel_c5g_gpio
  import c5g_gpio_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic        CLOCK_50_B5B,
  input  logic        CPU_RESET,
  input  logic        CLOCK_125_p,
  input  logic        CLOCK_50_B6A,
  input  logic        CLOCK_50_B7A,
  input  logic        CLOCK_50_B8A,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [7:0]  LEDG,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [35:0] GPIO
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic              clk;
  logic              rst;
  logic [3:0]        s1_q, s2_q, prev_q;
  logic [3:0]        ev;
  state_t            st_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy;
  logic              user_we, inc, dec;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, rd;
  logic              unused_ok;

  assign clk = CLOCK_50_B5B;
  assign rst = CPU_RESET;
  assign unused_ok = ^{CLOCK_125_p, CLOCK_50_B6A, CLOCK_50_B7A,
                       CLOCK_50_B8A, SW[9:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= KEY;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Press = synchronized level falling 1 -> 0
  assign ev   = prev_q & ~s2_q;
  assign busy = (st_q == CLEAR);

  assign user_we = !busy && !ev[3] && ev[0];
  assign inc     = !busy && !ev[3] && !ev[0] && ev[1];
  assign dec     = !busy && !ev[3] && !ev[0] && !ev[1] && ev[2];

  always_comb begin
    addr_d = addr_q;
    if (inc)      addr_d = addr_q + 1'b1;
    else if (dec) addr_d = addr_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
      unique case (st_q)
        IDLE: begin
          if (ev[3]) begin
            st_q  <= CLEAR;
            cnt_q <= '0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) st_q <= IDLE;
        end
      endcase
    end
  end

  // Reset blocks the write so an aborted clear leaves word cnt intact
  assign ram_we    = !rst && (busy || user_we);
  assign ram_addr  = busy ? cnt_q : addr_q;
  assign ram_wdata = busy ? '0 : DATA_W'(SW[7:0]);

  toplevel_c5g_gpio_spram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(rd)
  );

  assign LEDG = {4'b0, 4'(addr_q)};
  assign LEDR = {1'b0, busy, SW[7:0]};
  assign HEX0 = seg7(rd[3:0]);
  assign HEX1 = seg7(rd[7:4]);
  assign GPIO = {23'b0, user_we, 4'(addr_q), rd[7:0]};

endmodule

// File: tb/tb_toplevel_c5g_gpio.sv
// Directed bench for toplevel_c5g_gpio.
// Hand-computed expectations checked with immediate assertions.
module tb_toplevel_c5g_gpio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key = 4'h0;
  logic [9:0]  sw  = 10'h0;
  logic [7:0]  ledg;
  logic [9:0]  ledr;
  logic [6:0]  hex0, hex1;
  logic [35:0] gpio;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  int busy_cnt = 0;

  always #10 clk = ~clk;

  toplevel_c5g_gpio dut (
    .CLOCK_50_B5B(clk),
    .CPU_RESET   (rst),
    .CLOCK_125_p (1'b0),
    .CLOCK_50_B6A(1'b0),
    .CLOCK_50_B7A(1'b0),
    .CLOCK_50_B8A(1'b0),
    .KEY         (key),
    .SW          (sw),
    .LEDG        (ledg),
    .LEDR        (ledr),
    .HEX0        (hex0),
    .HEX1        (hex1),
    .GPIO        (gpio)
  );

  always @(negedge clk) begin
    if (gpio[12]) strobes++;
    if (ledr[8])  busy_cnt++;
  end

  task automatic chk(input string tag, input logic [35:0] obs,
                     input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk) key = ~mask;
    repeat (4) @(posedge clk);
    @(negedge clk) key = 4'hF;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    logic [7:0] exp_w;

    // Reset with all keys held pressed, then hold 2000 cycles
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    chk("idle_hex0", 36'(hex0), 36'h40);
    chk("idle_hex1", 36'(hex1), 36'h40);
    chk("idle_ledg", 36'(ledg), 36'h00);
    chk("idle_gpio", gpio, 36'h0);
    chk("idle_ledr", 36'(ledr), 36'h0);
    chk("idle_strobes", 36'(strobes), 36'd0);
    key = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    chk("release_strobes", 36'(strobes), 36'd0);

    // Write 0xA5 at address 0
    sw = 10'h0A5;
    press(4'b0001);
    chk("wr_strobes", 36'(strobes), 36'd1);
    chk("wr_hex1", 36'(hex1), 36'h08);
    chk("wr_hex0", 36'(hex0), 36'h12);
    chk("wr_gpio", gpio, 36'h0A5);
    chk("wr_ledr", 36'(ledr), 36'h0A5);

    // Wrap down and back up
    press(4'b0100);
    chk("dec_wrap_ledg", 36'(ledg), 36'h0F);
    chk("dec_wrap_gpio", gpio, 36'hF00);
    press(4'b0010);
    chk("inc_wrap_ledg", 36'(ledg), 36'h00);
    chk("inc_wrap_rd", 36'(gpio[7:0]), 36'hA5);

    // Words 2 and 3, then clear
    press(4'b0010);
    press(4'b0010);
    sw = 10'h03C;
    press(4'b0001);
    chk("w2_rd", 36'(gpio[7:0]), 36'h3C);
    chk("w2_hex1", 36'(hex1), 36'h30);
    chk("w2_hex0", 36'(hex0), 36'h46);
    press(4'b0010);
    sw = 10'h07E;
    press(4'b0001);
    chk("w3_rd", 36'(gpio[7:0]), 36'h7E);
    chk("w3_strobes", 36'(strobes), 36'd3);
    busy_cnt = 0;
    press(4'b1000);
    repeat (20) @(posedge clk);
    #1;
    chk("clr_busy_cycles", 36'(busy_cnt), 36'd16);
    chk("clr_ledr8", 36'(ledr[8]), 36'd0);
    chk("clr_addr_kept", 36'(ledg), 36'h03);
    chk("clr_w3", 36'(gpio[7:0]), 36'h00);
    chk("clr_strobes", 36'(strobes), 36'd3);
    press(4'b0100);
    chk("clr_w2", 36'(gpio[7:0]), 36'h00);
    press(4'b0100);
    press(4'b0100);
    chk("clr_w0_addr", 36'(ledg), 36'h00);
    chk("clr_w0", 36'(gpio[7:0]), 36'h00);

    // Write beats increment when both fall together
    sw = 10'h05A;
    press(4'b0011);
    chk("prio_addr", 36'(ledg), 36'h00);
    chk("prio_rd", 36'(gpio[7:0]), 36'h5A);
    chk("prio_strobes", 36'(strobes), 36'd4);

    // Clear beats write
    sw = 10'h0FF;
    press(4'b1001);
    repeat (20) @(posedge clk);
    #1;
    chk("prio3_rd", 36'(gpio[7:0]), 36'h00);
    chk("prio3_strobes", 36'(strobes), 36'd4);

    // Fill every word with 0x10+i
    for (int i = 0; i < 16; i++) begin
      sw = 10'(8'h10 + i);
      press(4'b0001);
      press(4'b0010);
    end
    chk("fill_addr", 36'(ledg), 36'h00);
    chk("fill_w0", 36'(gpio[7:0]), 36'h10);

    // Clear, then reset once words 0..4 are written
    @(negedge clk) key = 4'b0111;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (ledr[8]) seen = 1'b1;
    end
    chk("abort_busy_seen", 36'(seen), 36'd1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    key = 4'hF;
    chk("abort_ledr8", 36'(ledr[8]), 36'd0);
    chk("abort_hex0", 36'(hex0), 36'h40);
    chk("abort_hex1", 36'(hex1), 36'h40);
    chk("abort_gpio", 36'(gpio[12:0]), 36'h0);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      exp_w = (i < 5) ? 8'h00 : 8'(8'h10 + i);
      chk($sformatf("abort_word%0d", i), 36'(gpio[7:0]), 36'(exp_w));
      press(4'b0010);
    end
    chk("abort_final_addr", 36'(ledg), 36'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
